// File: rtl/button_press_decoder.sv
// button_press_decoder: debounces five raw buttons into one-cycle press pulses and classifies power/menu presses as short or long.
//   clk, rst (sync, active-high)
//   btn_power_menu, btn_first_level, btn_second_level, btn_third_level, btn_self_clean : raw button levels, high = pressed
//   power_menu_short_press, power_menu_long_press : one-cycle power/menu classification pulses
//   first_level_press, second_level_press, third_level_press, self_clean_press : one-cycle debounced press pulses
//   Define BUTTON_SYNC_2FF_EN to insert a two-flop synchronizer on every raw input (+2 cycles latency).
module button_press_decoder #(
  parameter int DEBOUNCE_CYCLES   = 2_000_000,
  parameter int LONG_PRESS_CYCLES = 300_000_000,
  parameter int CNT_W             = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_power_menu,
  input  logic btn_first_level,
  input  logic btn_second_level,
  input  logic btn_third_level,
  input  logic btn_self_clean,
  output logic power_menu_short_press,
  output logic power_menu_long_press,
  output logic first_level_press,
  output logic second_level_press,
  output logic third_level_press,
  output logic self_clean_press
);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LMAX = CNT_W'(LONG_PRESS_CYCLES - 1);
  typedef enum logic [1:0] {PWR_RELEASED, PWR_HELD, PWR_LONG} pwr_t;
  // bit 0 is power/menu, bits 4:1 are first/second/third level and self-clean
  logic [4:0] raw, smp, stb, stb_q, rise;
  logic [3:0] lvl;
  logic       lvl_ok;
  pwr_t             state, state_nxt;
  logic [CNT_W-1:0] hcnt, hcnt_nxt;
  logic             short_nxt, long_nxt;
  assign raw = {btn_self_clean, btn_third_level, btn_second_level, btn_first_level, btn_power_menu};
`ifdef BUTTON_SYNC_2FF_EN
  logic [4:0] sync_1, sync_2;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end
  assign smp = sync_2;
`else
  assign smp = raw;
`endif
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic             s;
    logic [CNT_W-1:0] dcnt;
    always_ff @(posedge clk) begin
      if (rst) begin
        s    <= 1'b0;
        dcnt <= '0;
      end else if (smp[i] == s) begin
        dcnt <= '0;
      end else if (dcnt == DMAX) begin
        s    <= smp[i];
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
    assign stb[i] = s;
  end
  always_ff @(posedge clk) begin
    if (rst) stb_q <= '0;
    else     stb_q <= stb;
  end
  assign rise = stb & ~stb_q;
  assign lvl  = rise[4:1];
  // two or more coincident level/clean presses are ambiguous, so none is reported
  assign lvl_ok = (lvl & (lvl - 4'd1)) == 4'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PWR_RELEASED;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    case (state)
      PWR_RELEASED: if (rise[0]) begin
        state_nxt = PWR_HELD;
        hcnt_nxt  = '0;
      end
      PWR_HELD: if (!stb[0]) state_nxt = PWR_RELEASED;
        else if (hcnt == LMAX) state_nxt = PWR_LONG;
        else hcnt_nxt = hcnt + 1'b1;
      PWR_LONG: if (!stb[0]) state_nxt = PWR_RELEASED;
      default: state_nxt = PWR_RELEASED;
    endcase
  end
  always_comb begin
    short_nxt = state == PWR_HELD && !stb[0];
    long_nxt  = state == PWR_HELD && stb[0] && hcnt == LMAX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      power_menu_short_press <= 1'b0;
      power_menu_long_press  <= 1'b0;
      {self_clean_press, third_level_press, second_level_press, first_level_press} <= '0;
    end else begin
      power_menu_short_press <= short_nxt;
      power_menu_long_press  <= long_nxt;
      {self_clean_press, third_level_press, second_level_press, first_level_press} <= lvl_ok ? lvl : 4'd0;
    end
  end
endmodule

// File: doc/button_press_decoder.md
# button_press_decoder

Front-end input stage of the range-hood controller. It takes the five raw push-button levels from the board and turns them into one-cycle press pulses for the mode state machine. The power/menu button is classified as short press or long press; the level and self-clean buttons produce a pulse on debounced press. All outputs are registered, single-cycle pulses in the `clk` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive cycles a sampled input must differ from its debounced level before that level flips (20 ms at 100 MHz); must be ≥ 2.
- `LONG_PRESS_CYCLES`, default 300_000_000: cycles the debounced power button must stay held to count as a long press (3 s at 100 MHz); must be > `DEBOUNCE_CYCLES`.
- `CNT_W`, default 32: width of debounce and hold counters; must hold `LONG_PRESS_CYCLES`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `btn_power_menu`  in  1  raw power/menu button, high = pressed, asynchronous.
- `btn_first_level`, `btn_second_level`, `btn_third_level`, `btn_self_clean`  in  1 each  raw level/clean buttons, high = pressed, asynchronous.
- `power_menu_short_press`  out  1  one-cycle pulse: power released before the long threshold.
- `power_menu_long_press`  out  1  one-cycle pulse: power held for `LONG_PRESS_CYCLES`.
- `first_level_press`, `second_level_press`, `third_level_press`, `self_clean_press`  out  1 each  one-cycle pulse on debounced press.

## Operation
- **Per-button debouncer** (×5, identical):
  - Holds a debounced level `stb` (reset 0) and a counter `dcnt` (reset 0).
  - Each cycle, if sampled input equals `stb`, then `dcnt` ← 0.
  - Otherwise, if `dcnt == DEBOUNCE_CYCLES-1`, then `stb` ← sampled input and `dcnt` ← 0; else `dcnt` ← `dcnt` + 1.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `stb`.
- **Level/clean buttons:**
  - A raw press pulse is generated on the `stb` 0→1 edge.
  - Release produces nothing.
  - A press held indefinitely yields exactly one pulse.
- **Multi-press rejection:** if two or more of the four level/clean raw pulses coincide in the same cycle, all four outputs stay low that cycle (no priority).
- **Power FSM** (states `PWR_RELEASED`, `PWR_HELD`, `PWR_LONG`; reset `PWR_RELEASED`), with hold counter `hcnt`:
  - `PWR_RELEASED` → `PWR_HELD` on `stb` 0→1; `hcnt` ← 0.
  - `PWR_HELD`, `stb` high:
    - if `hcnt == LONG_PRESS_CYCLES-1`, pulse `power_menu_long_press` and go to `PWR_LONG`;
    - else `hcnt` ← `hcnt` + 1.
  - `PWR_HELD`, `stb` low: pulse `power_menu_short_press` and go to `PWR_RELEASED`.
  - `PWR_LONG`: `hcnt` frozen, no pulses; → `PWR_RELEASED` when `stb` goes low (no short pulse).
  - Short and long are mutually exclusive per physical press.
  - Power pulses are independent of level/clean pulses; both may fire in the same cycle.
- **Arithmetic:** counters are unsigned `CNT_W`-bit, never wrap (bounded by compare-and-clear / freeze).

## Timing
- All seven outputs reset to 0, as do all `stb`, counters and the FSM state.
- Every output is a register; pulse width is exactly 1 cycle.
- **Press latency:** raw input first sampled high at edge N and held stable → level/clean pulse high in the cycle after edge N+`DEBOUNCE_CYCLES` (plus 2 cycles with synchronizer, see Configuration).
- **Long press:** `power_menu_long_press` is high `LONG_PRESS_CYCLES` cycles after the power press pulse would have been generated.
- **Short press:** `power_menu_short_press` is high the cycle after the debounced power release completes.
- **Reset mid-operation:** everything clears in the cycle `rst` is sampled high, and no pulse is emitted that cycle.
  - A button still held when `rst` drops is treated as a new press: it passes debounce again and then pulses normally.
  - The power button in that case restarts the hold count from 0.
- No handshake: downstream must sample every cycle.

## Configuration
- `BUTTON_SYNC_2FF_EN`:
  - Defined: each raw input passes through a two-flop synchronizer (reset 0) before the debouncer; adds 2 cycles latency to every pulse.
  - Undefined: raw inputs feed the debouncers directly (simulation/pre-synchronized inputs only); latency as in Timing with no additional cycles.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`, `LONG_PRESS_CYCLES=20`, and `BUTTON_SYNC_2FF_EN` undefined.
- **Glitch rejection:** `btn_first_level` high 3 cycles, then low → no output pulse ever; `dcnt` returns to 0.
- **Clean press:** `btn_second_level` high from edge 10 for 50 cycles → `second_level_press` high only in the cycle after edge 14, once.
- **Short press:** `btn_power_menu` high 10 cycles, then low → one `power_menu_short_press` pulse after release debounce; no long pulse.
- **Long press:** `btn_power_menu` held 100 cycles → one `power_menu_long_press` pulse ≈20 cycles after the debounced press; no short pulse on release.
- **Simultaneous press:** `btn_first_level` and `btn_third_level` rise on the same edge → no level pulse. The same pair offset by 1 cycle → both pulse in successive cycles.
- **Reset mid-hold:** power held 15 cycles, `rst` high 1 cycle while still held → all outputs 0. The next long pulse arrives 4+20 cycles after `rst` falls.
